// File: rtl/wired_cache_line_mover.sv
// Line refill/writeback engine: moves 128-bit cache lines between the data SRAM
// M port and a 32-bit, 4-beat burst memory bus, one job at a time.
module wired_cache_line_mover (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_way_i,
  input  logic [31:0]       req_addr_i,
  input  logic              req_wb_i,
  input  logic [31:0]       req_wb_addr_i,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        m_way_o,
  output logic [11:0]       m_addr_o,
  output logic [3:0][3:0]   m_wstrb_o,
  output logic [3:0][31:0]  m_wdata_o,
  input  logic [3:0][31:0]  m_rdata_i,
  output logic              rd_req_valid_o,
  input  logic              rd_req_ready_i,
  output logic [31:0]       rd_addr_o,
  input  logic              rdata_valid_i,
  input  logic [31:0]       rdata_i,
  input  logic              rdata_last_i,
  output logic              wr_req_valid_o,
  input  logic              wr_req_ready_i,
  output logic [31:0]       wr_addr_o,
  output logic              wr_data_valid_o,
  input  logic              wr_data_ready_i,
  output logic [31:0]       wr_data_o,
  output logic              wr_data_last_o,
  input  logic              wr_resp_valid_i
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WB_READ  = 4'd1;
  localparam logic [3:0] S_WB_CAP   = 4'd2;
  localparam logic [3:0] S_WB_REQ   = 4'd3;
  localparam logic [3:0] S_WB_DATA  = 4'd4;
  localparam logic [3:0] S_WB_RESP  = 4'd5;
  localparam logic [3:0] S_RF_REQ   = 4'd6;
  localparam logic [3:0] S_RF_DATA  = 4'd7;
  localparam logic [3:0] S_RF_WRITE = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  logic [3:0]       state_q, state_d;
  logic [1:0]       way_q, way_d;
  logic [31:4]      rf_addr_q, rf_addr_d;
  logic [31:4]      wb_addr_q, wb_addr_d;
  logic [1:0]       beat_q, beat_d;
  logic [3:0][31:0] buf_q, buf_d;
  logic             err_q, err_d;
  logic [1:0]       m_way_q, m_way_d;
  logic [11:0]      m_addr_q, m_addr_d;

  // Byte-offset bits of the job addresses carry no meaning for line moves.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr_i[3:0], req_wb_addr_i[3:0]};

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valids are pure state decodes, so they and their address/data
  // stay constant until the matching ready is seen.
  always_comb begin
    state_d   = state_q;
    way_d     = way_q;
    rf_addr_d = rf_addr_q;
    wb_addr_d = wb_addr_q;
    beat_d    = beat_q;
    buf_d     = buf_q;
    err_d     = err_q;
    m_way_d   = m_way_q;
    m_addr_d  = m_addr_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          way_d     = req_way_i;
          rf_addr_d = req_addr_i[31:4];
          wb_addr_d = req_wb_addr_i[31:4];
          if (req_wb_i) begin
            state_d  = S_WB_READ;
            m_way_d  = req_way_i;
            m_addr_d = {req_wb_addr_i[11:4], 4'b0};
          end else begin
            state_d = S_RF_REQ;
          end
        end
      end
      S_WB_READ: state_d = S_WB_CAP;
      S_WB_CAP: begin
        buf_d   = m_rdata_i;
        state_d = S_WB_REQ;
      end
      S_WB_REQ: begin
        beat_d = 2'd0;
        if (wr_req_ready_i) state_d = S_WB_DATA;
      end
      S_WB_DATA: begin
        if (wr_data_ready_i) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = S_WB_RESP;
        end
      end
      S_WB_RESP: begin
        if (wr_resp_valid_i) state_d = S_RF_REQ;
      end
      S_RF_REQ: begin
        beat_d = 2'd0;
        if (rd_req_ready_i) state_d = S_RF_DATA;
      end
      S_RF_DATA: begin
        if (rdata_valid_i) begin
          buf_d[beat_q] = rdata_i;
          beat_d        = beat_q + 2'd1;
          // The beat count decides completion; a misplaced last only flags.
          if ((beat_q != 2'd3) == rdata_last_i) err_d = 1'b1;
          if (beat_q == 2'd3) begin
            state_d  = S_RF_WRITE;
            m_way_d  = way_q;
            m_addr_d = {rf_addr_q[11:4], 4'b0};
          end
        end
      end
      S_RF_WRITE: state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      way_q     <= 2'd0;
      rf_addr_q <= '0;
      wb_addr_q <= '0;
      beat_q    <= 2'd0;
      buf_q     <= '0;
      err_q     <= 1'b0;
      m_way_q   <= 2'd0;
      m_addr_q  <= 12'd0;
    end else begin
      state_q   <= state_d;
      way_q     <= way_d;
      rf_addr_q <= rf_addr_d;
      wb_addr_q <= wb_addr_d;
      beat_q    <= beat_d;
      buf_q     <= buf_d;
      err_q     <= err_d;
      m_way_q   <= m_way_d;
      m_addr_q  <= m_addr_d;
    end
  end

  assign req_ready_o     = (state_q == S_IDLE);
  assign done_o          = (state_q == S_DONE);
  assign err_o           = err_q;
  assign m_way_o         = m_way_q;
  assign m_addr_o        = m_addr_q;
  assign m_wstrb_o       = (state_q == S_RF_WRITE) ? {16{1'b1}} : 16'h0000;
  assign m_wdata_o       = buf_q;
  assign rd_req_valid_o  = (state_q == S_RF_REQ);
  assign rd_addr_o       = {rf_addr_q, 4'b0};
  assign wr_req_valid_o  = (state_q == S_WB_REQ);
  assign wr_addr_o       = {wb_addr_q, 4'b0};
  assign wr_data_valid_o = (state_q == S_WB_DATA);
  assign wr_data_o       = buf_q[beat_q];
  assign wr_data_last_o  = (state_q == S_WB_DATA) && (beat_q == 2'd3);

endmodule

// File: tb/tb_wired_cache_line_mover.sv
// Bench for wired_cache_line_mover: an SRAM read model plus a bus responder
// driven per cycle, with queues of expected write beats and SRAM line writes.
module tb_wired_cache_line_mover;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [1:0]        req_way_i;
  logic [31:0]       req_addr_i;
  logic              req_wb_i;
  logic [31:0]       req_wb_addr_i;
  logic              done_o;
  logic              err_o;
  logic [1:0]        m_way_o;
  logic [11:0]       m_addr_o;
  logic [3:0][3:0]   m_wstrb_o;
  logic [3:0][31:0]  m_wdata_o;
  logic [3:0][31:0]  m_rdata_i;
  logic              rd_req_valid_o;
  logic              rd_req_ready_i;
  logic [31:0]       rd_addr_o;
  logic              rdata_valid_i;
  logic [31:0]       rdata_i;
  logic              rdata_last_i;
  logic              wr_req_valid_o;
  logic              wr_req_ready_i;
  logic [31:0]       wr_addr_o;
  logic              wr_data_valid_o;
  logic              wr_data_ready_i;
  logic [31:0]       wr_data_o;
  logic              wr_data_last_o;
  logic              wr_resp_valid_i;

  always #5 clk = ~clk;

  wired_cache_line_mover dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_way_i(req_way_i),
    .req_addr_i(req_addr_i), .req_wb_i(req_wb_i), .req_wb_addr_i(req_wb_addr_i),
    .done_o(done_o), .err_o(err_o),
    .m_way_o(m_way_o), .m_addr_o(m_addr_o), .m_wstrb_o(m_wstrb_o),
    .m_wdata_o(m_wdata_o), .m_rdata_i(m_rdata_i),
    .rd_req_valid_o(rd_req_valid_o), .rd_req_ready_i(rd_req_ready_i), .rd_addr_o(rd_addr_o),
    .rdata_valid_i(rdata_valid_i), .rdata_i(rdata_i), .rdata_last_i(rdata_last_i),
    .wr_req_valid_o(wr_req_valid_o), .wr_req_ready_i(wr_req_ready_i), .wr_addr_o(wr_addr_o),
    .wr_data_valid_o(wr_data_valid_o), .wr_data_ready_i(wr_data_ready_i),
    .wr_data_o(wr_data_o), .wr_data_last_o(wr_data_last_o),
    .wr_resp_valid_i(wr_resp_valid_i)
  );

  // SRAM model: one-cycle read latency, returns the line of the addressed way
  // only when the index matches the victim; anything else reads as a marker.
  logic [127:0] sram [4];
  logic [11:0]  vic_idx;
  always @(posedge clk) begin
    m_rdata_i <= (m_addr_o == vic_idx) ? sram[m_way_o] : {4{32'hBAD0_BAD0}};
  end

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0]  exp_q[$];
  logic [127:0] line_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic drive_idle();
    req_valid_i = 0; req_way_i = 0; req_addr_i = 0; req_wb_i = 0; req_wb_addr_i = 0;
    rd_req_ready_i = 0; rdata_valid_i = 0; rdata_i = 0; rdata_last_i = 0;
    wr_req_ready_i = 0; wr_data_ready_i = 0; wr_resp_valid_i = 0;
  endtask

  // One job, cycle by cycle at the falling edge. Cycle 0 is the accept cycle.
  task automatic run_job(input logic [1:0] way, input logic [31:0] addr,
                         input logic wb, input logic [31:0] wb_addr,
                         input logic [127:0] vline, input logic [127:0] line,
                         input logic [3:0] last_mask, input int stall,
                         input logic gap, input logic hold_req, input int abort_beats,
                         input logic exp_err, input int exp_rq, input int exp_wr,
                         input int exp_dn);
    int c, rq_cyc, wr_cyc, dn_cyc, rd_hs, sent, wsent, wlast_cyc, nwr;
    int rwait, wqwait, wdwait, rspwait;
    logic done_seen, resp_sent, busy_bad, rd_early, toggle, abort_now, got_idle;
    rq_cyc = -1; wr_cyc = -1; dn_cyc = -1; rd_hs = -1; sent = 0; wsent = 0;
    wlast_cyc = -1; nwr = 0; rwait = 0; wqwait = 0; wdwait = 0; rspwait = 0;
    done_seen = 0; resp_sent = 0; busy_bad = 0; rd_early = 0; toggle = 0;
    abort_now = 0; got_idle = 0;
    if (wb) begin
      sram[way] = vline;
      vic_idx   = {wb_addr[11:4], 4'b0};
      for (int k = 0; k < 4; k++) exp_q.push_back(vline[k*32 +: 32]);
    end
    if (abort_beats < 0) line_q.push_back(line);
    for (int w = 0; w < 50 && !got_idle; w++) begin
      @(negedge clk);
      got_idle = req_ready_o;
    end
    check("idle_before_job", got_idle, 1'b1);
    req_valid_i = 1; req_way_i = way; req_addr_i = addr; req_wb_i = wb;
    req_wb_addr_i = wb_addr;
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(negedge clk);
      c = cyc;
      if (abort_now) break;
      rd_req_ready_i = 0; wr_req_ready_i = 0; wr_data_ready_i = 0;
      wr_resp_valid_i = 0; rdata_valid_i = 0; rdata_last_i = 0;
      rdata_i = 32'hDEAD_0000 | cyc;
      if (done_seen && c == dn_cyc + 1) begin
        check("ready_after_done", req_ready_o, 1'b1);
        break;
      end
      if (req_ready_o) busy_bad = 1;
      if (rd_req_valid_o) begin
        if (rq_cyc < 0) rq_cyc = c;
        if (wb && !resp_sent) rd_early = 1;
        check("rd_addr", rd_addr_o, {addr[31:4], 4'b0});
        if (rwait >= stall) begin rd_req_ready_i = 1; rd_hs = c; end
        else rwait++;
      end
      if (rd_hs >= 0 && c > rd_hs && sent < 4) begin
        if (!gap || toggle) begin
          rdata_valid_i = 1;
          rdata_i       = line[sent*32 +: 32];
          rdata_last_i  = last_mask[sent];
          sent++;
          if (sent == abort_beats) abort_now = 1;
        end
        toggle = ~toggle;
      end else if (gap) begin
        // Stray beats outside the refill data phase must be ignored.
        rdata_valid_i = 1;
        rdata_last_i  = 1;
      end
      if (wr_req_valid_o) begin
        check("wr_addr", wr_addr_o, {wb_addr[31:4], 4'b0});
        if (wqwait >= stall) wr_req_ready_i = 1;
        else wqwait++;
      end
      if (wr_data_valid_o) begin
        if (exp_q.size() == 0) check("wb_extra_beat", 1'b1, 1'b0);
        else begin
          check("wb_data", wr_data_o, exp_q[0]);
          check("wb_last", wr_data_last_o, wsent == 3);
          if (wsent != 1 || wdwait >= stall) begin
            wr_data_ready_i = 1;
            void'(exp_q.pop_front());
            wsent++;
            if (wsent == 4) wlast_cyc = c;
          end else wdwait++;
        end
      end
      if (wlast_cyc >= 0 && c > wlast_cyc && !resp_sent) begin
        if (rspwait >= stall) begin wr_resp_valid_i = 1; resp_sent = 1; end
        else rspwait++;
      end
      if (m_wstrb_o != 16'h0) begin
        wr_cyc = c;
        nwr++;
        check("m_wstrb", m_wstrb_o, 16'hFFFF);
        check("m_way", m_way_o, way);
        check("m_addr", m_addr_o, {addr[11:4], 4'b0});
        if (line_q.size() == 0) check("line_extra_write", 1'b1, 1'b0);
        else check("m_wdata", m_wdata_o, line_q.pop_front());
      end
      if (done_o) begin
        if (done_seen) check("done_twice", 1'b1, 1'b0);
        else begin done_seen = 1; dn_cyc = c; end
      end
      req_valid_i = hold_req && !done_seen;
    end
    if (abort_beats >= 0) return;
    check("job_finished", done_seen, 1'b1);
    check("busy_ready_low", busy_bad, 1'b0);
    check("line_writes", nwr, 1);
    check("err", err_o, exp_err);
    if (wb) begin
      check("no_rd_before_resp", rd_early, 1'b0);
      check("wb_beats", wsent, 4);
    end
    if (exp_rq >= 0) begin
      check("lat_rd_req", rq_cyc, exp_rq);
      check("lat_write", wr_cyc, exp_wr);
      check("lat_done", dn_cyc, exp_dn);
    end
    exp_q.delete();
    line_q.delete();
  endtask

  initial begin
    logic [127:0] va, la;
    drive_idle();
    vic_idx = 12'hFFF;
    for (int k = 0; k < 4; k++) sram[k] = '0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready_o, 1'b1);
    check("rst_outs", {done_o, err_o, rd_req_valid_o, wr_req_valid_o, wr_data_valid_o,
                       wr_data_last_o, m_wstrb_o, m_way_o, m_addr_o}, '0);
    check("rst_data", {rd_addr_o, wr_addr_o, wr_data_o, m_wdata_o}, '0);
    rst_n = 1;
    @(negedge clk);

    // Refill only, zero-wait: latency 1/6/7, ready back at 8.
    run_job(2'd2, 32'h0000_1A30, 0, 0, '0,
            {32'h44, 32'h33, 32'h22, 32'h11}, 4'b1000, 0, 0, 0, -1, 0, 1, 6, 7);
    // Writeback then refill, victim {D,C,B,A}.
    run_job(2'd1, 32'h0000_2C40, 1, 32'h8000_5B7C,
            {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001},
            {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hF0F0_F0F0},
            4'b1000, 0, 0, 0, -1, 0, -1, 0, 0);
    // Backpressure of 5 cycles on every handshake.
    va = {$urandom, $urandom, $urandom, $urandom};
    la = {$urandom, $urandom, $urandom, $urandom};
    run_job(2'd3, 32'hC000_0FF0, 1, 32'h4000_0010, va, la, 4'b1000, 5, 0, 0, -1,
            0, -1, 0, 0);
    // Gapped beats with last on beat 2: line still needs 4 beats, err sticks.
    la = {$urandom, $urandom, $urandom, $urandom};
    run_job(2'd0, 32'h0000_0120, 0, 0, '0, la, 4'b0100, 0, 1, 0, -1, 1, -1, 0, 0);
    // req_valid held high through a busy job; err from before stays set.
    la = {$urandom, $urandom, $urandom, $urandom};
    run_job(2'd2, 32'h7777_7770, 0, 0, '0, la, 4'b1000, 0, 0, 1, -1, 1, 1, 6, 7);
    check("one_job_accepted", req_ready_o, 1'b1);

    // Reset during RF_DATA after 2 beats.
    la = {$urandom, $urandom, $urandom, $urandom};
    run_job(2'd1, 32'h0000_3330, 0, 0, '0, la, 4'b1000, 0, 0, 0, 2, 0, -1, 0, 0);
    #2 rst_n = 0;
    drive_idle();
    #1;
    check("async_rst_ready", req_ready_o, 1'b1);
    check("async_rst_outs", {done_o, err_o, rd_req_valid_o, wr_req_valid_o, wr_data_valid_o,
                             wr_data_last_o, m_wstrb_o, m_way_o, m_addr_o}, '0);
    check("async_rst_data", {rd_addr_o, wr_addr_o, wr_data_o, m_wdata_o}, '0);
    exp_q.delete();
    line_q.delete();
    @(negedge clk);
    rst_n = 1;
    va = {$urandom, $urandom, $urandom, $urandom};
    la = {$urandom, $urandom, $urandom, $urandom};
    run_job(2'd0, 32'h0000_0AB0, 1, 32'h0000_0CD0, va, la, 4'b1000, 0, 0, 0, -1,
            0, -1, 0, 0);

    for (int j = 0; j < 4; j++) begin
      va = {$urandom, $urandom, $urandom, $urandom};
      la = {$urandom, $urandom, $urandom, $urandom};
      run_job(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), $urandom,
              va, la, 4'b1000, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, -1,
              0, -1, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
